// File: rtl/rc_ctl_axil_pkg.sv
// Shared constants for the rc_ctl S00_AXI register port.
package rc_ctl_axil_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Register indices as decoded from addr[3:2].
  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_STEER = 2'd1;
  localparam logic [1:0] REG_THROT = 2'd2;
  localparam logic [1:0] REG_AUX   = 2'd3;

  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned NUM_REGS = 4;

endpackage

// File: rtl/rc_ctl_axil_regfile.sv
// 4x32 byte-strobed register array with one write port, an async read mux
// and a one-cycle update pulse per written register.
module rc_ctl_axil_regfile
  import rc_ctl_axil_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   we_i,
  input  logic [1:0]             widx_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
  input  logic [1:0]             ridx_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [DataWidth-1:0]   ctrl_o,
  output logic [DataWidth-1:0]   steer_o,
  output logic [DataWidth-1:0]   throt_o,
  output logic [DataWidth-1:0]   aux_o,
  output logic [NUM_REGS-1:0]    upd_o
);

  logic [DataWidth-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]  upd_q, upd_d;

  // Byte-lane write into the selected register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < DataWidth / 8; b++) begin
        if (wstrb_i[b]) regs_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Update pulse fires even for an all-zero strobe.
  always_comb begin
    upd_d = '0;
    if (we_i) upd_d[widx_i] = 1'b1;
  end

  // Register the pulse so it lines up with the new register contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) upd_q <= '0;
    else         upd_q <= upd_d;
  end

  assign rdata_o = regs_q[ridx_i];
  assign ctrl_o  = regs_q[REG_CTRL];
  assign steer_o = regs_q[REG_STEER];
  assign throt_o = regs_q[REG_THROT];
  assign aux_o   = regs_q[REG_AUX];
  assign upd_o   = upd_q;

endmodule

// File: rtl/rc_ctl_s00_axil_slave.sv
// AXI4-Lite responder for the rc_ctl register port: independent AW/W holding
// buffers, a single-outstanding read channel, and the register file.
module rc_ctl_s00_axil_slave
  import rc_ctl_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [NUM_REGS-1:0]             reg_upd_o
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

  logic          rst_done_q;
  logic          aw_full_q, aw_full_d;
  logic [1:0]    aw_idx_q, aw_idx_d;
  logic          w_full_q, w_full_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [1:0]    wr_idx;
  logic [DW-1:0] wr_data, rf_rdata;
  logic [SW-1:0] wr_strb;

  // Protection bits and address bits outside [3:2] have no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = rst_done_q & ~aw_full_q;
  assign S_AXI_WREADY  = rst_done_q & ~w_full_q;
  assign S_AXI_ARREADY = rst_done_q & ~rvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // A beat arriving this cycle counts as already buffered, so AW+W together
  // commit on the same edge they handshake.
  assign commit  = (aw_full_q | aw_hs) & (w_full_q | w_hs) & (~bvalid_q | S_AXI_BREADY);
  assign wr_idx  = aw_full_q ? aw_idx_q : S_AXI_AWADDR[ADDR_LSB +: 2];
  assign wr_data = w_full_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_full_q ? w_strb_q : S_AXI_WSTRB;

  // Write-channel next state: holding buffers and B response.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[ADDR_LSB +: 2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (S_AXI_BREADY) bvalid_d = 1'b0;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end
  end

  // Read-channel next state: capture on AR, hold until RREADY.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rf_rdata;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // Channel state; READY outputs stay low until the first edge after reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_done_q <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rst_done_q <= 1'b1;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  rc_ctl_axil_regfile #(
    .DataWidth(DW)
  ) u_regfile (
    .clk_i  (ACLK),
    .rst_ni (ARESETN),
    .we_i   (commit),
    .widx_i (wr_idx),
    .wdata_i(wr_data),
    .wstrb_i(wr_strb),
    .ridx_i (S_AXI_ARADDR[ADDR_LSB +: 2]),
    .rdata_o(rf_rdata),
    .ctrl_o (reg0_o),
    .steer_o(reg1_o),
    .throt_o(reg2_o),
    .aux_o  (reg3_o),
    .upd_o  (reg_upd_o)
  );

endmodule
